// File: rtl/rat_flags.sv
// rat_flags: architectural C/Z/I flag state for the RAT MCU.
// Holds live C and Z, their shadow copies used across interrupt service,
// the interrupt-enable flag I, and the registered interrupt request
// derived from a synchronized, edge-detected external INT line.
module rat_flags (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic INT_REQ
);

    logic c_load_val;
    logic z_load_val;
    logic c_next;
    logic z_next;
    logic i_next;
    logic int_sync_p0;
    logic int_sync_p1;
    logic int_prev_p2;
    logic int_edge;
    logic pending;
    logic pending_next;

    // Select load source and resolve next-state priorities for the flags.
    always_comb begin
        c_load_val = FLG_LD_SEL ? SHAD_C : C_IN;
        z_load_val = FLG_LD_SEL ? SHAD_Z : Z_IN;

        c_next = C_FLAG;
        if (FLG_C_CLR)
            c_next = 1'b0;
        else if (FLG_C_SET)
            c_next = 1'b1;
        else if (FLG_C_LD)
            c_next = c_load_val;

        z_next = Z_FLAG;
        if (FLG_Z_LD)
            z_next = z_load_val;

        // Taking the interrupt disables further interrupts on the same edge.
        i_next = I_FLAG;
        if (I_CLR || INT_ACK)
            i_next = 1'b0;
        else if (I_SET)
            i_next = 1'b1;
    end

    // Live and shadow flags; both sides read pre-edge values so a
    // simultaneous save and restore swaps live and shadow.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            C_FLAG <= 1'b0;
            Z_FLAG <= 1'b0;
            I_FLAG <= 1'b0;
            SHAD_C <= 1'b0;
            SHAD_Z <= 1'b0;
        end else begin
            C_FLAG <= c_next;
            Z_FLAG <= z_next;
            I_FLAG <= i_next;
            if (FLG_SHAD_LD) begin
                SHAD_C <= C_FLAG;
                SHAD_Z <= Z_FLAG;
            end
        end
    end

    // A new rising edge wins over an acknowledge in the same cycle so the
    // event is not dropped.
    assign int_edge = int_sync_p1 & ~int_prev_p2;

    always_comb begin
        pending_next = pending;
        if (int_edge)
            pending_next = 1'b1;
        else if (INT_ACK)
            pending_next = 1'b0;
    end

    // Two-flop synchronizer, edge-detect history, pending latch and request.
    // int_prev_p2 resets to 0 so INT held high across reset release still
    // registers as one edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            int_sync_p0 <= 1'b0;
            int_sync_p1 <= 1'b0;
            int_prev_p2 <= 1'b0;
            pending     <= 1'b0;
            INT_REQ     <= 1'b0;
        end else begin
            int_sync_p0 <= INT;
            int_sync_p1 <= int_sync_p0;
            int_prev_p2 <= int_sync_p1;
            pending     <= pending_next;
            INT_REQ     <= pending & I_FLAG & ~INT_ACK;
        end
    end

endmodule

// File: tb/tb_rat_flags.sv
// Testbench for rat_flags: directed vectors drive the strobes, each step
// pushes the hand-computed output vector {C,Z,I,SHAD_C,SHAD_Z,INT_REQ}
// into a queue, and an independent monitor pops and compares on the
// falling edge.
module tb_rat_flags;

    logic CLK = 1'b0;
    logic RST, C_IN, Z_IN, FLG_C_LD, FLG_C_SET, FLG_C_CLR, FLG_Z_LD;
    logic FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, INT, INT_ACK;
    logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ;

    int n_cmp = 0;
    int n_bad = 0;
    string      q_name[$];
    logic [5:0] q_exp[$];

    always #5 CLK = ~CLK;

    rat_flags dut (
        .CLK(CLK), .RST(RST), .C_IN(C_IN), .Z_IN(Z_IN),
        .FLG_C_LD(FLG_C_LD), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
        .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET(I_SET), .I_CLR(I_CLR), .INT(INT), .INT_ACK(INT_ACK),
        .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG),
        .SHAD_C(SHAD_C), .SHAD_Z(SHAD_Z), .INT_REQ(INT_REQ)
    );

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            while (q_exp.size() > 0) begin
                string      nm;
                logic [5:0] ex;
                logic [5:0] got;
                nm  = q_name.pop_front();
                ex  = q_exp.pop_front();
                got = {C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ};
                n_cmp++;
                if (got !== ex) begin
                    n_bad++;
                    $display("FAIL %s: got CZI_SCSZ_REQ=%b expected %b", nm, got, ex);
                end
            end
        end
    end

    task automatic expect_now(input string nm, input logic [5:0] ex);
        q_name.push_back(nm);
        q_exp.push_back(ex);
    endtask

    task automatic clear_strobes();
        FLG_C_LD = 0; FLG_C_SET = 0; FLG_C_CLR = 0; FLG_Z_LD = 0;
        FLG_LD_SEL = 0; FLG_SHAD_LD = 0; I_SET = 0; I_CLR = 0; INT_ACK = 0;
    endtask

    // One clock with the currently applied strobes; expected state after the edge.
    task automatic cyc(input string nm, input logic [5:0] ex);
        @(posedge CLK);
        #1;
        expect_now(nm, ex);
        @(negedge CLK);
        #1;
        clear_strobes();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1; C_IN = 0; Z_IN = 0; INT = 0;
        clear_strobes();
        repeat (2) @(negedge CLK);
        RST = 0;

        // vector order: {C, Z, I, SHAD_C, SHAD_Z, INT_REQ}
        cyc("reset_idle", 6'b000000);

        C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc("alu_load", 6'b110000);

        C_IN = 1; FLG_C_SET = 1; FLG_C_CLR = 1; FLG_C_LD = 1;
        cyc("c_clr_prio", 6'b010000);

        C_IN = 1; Z_IN = 0; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc("load_c1z0", 6'b100000);

        FLG_SHAD_LD = 1;
        cyc("shad_save", 6'b100100);

        C_IN = 0; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc("alu_c0z1", 6'b010100);

        FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1;
        cyc("restore", 6'b100100);

        C_IN = 0; Z_IN = 0; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc("alu_c0z0", 6'b000100);

        FLG_SHAD_LD = 1;
        cyc("shad_zero", 6'b000000);

        C_IN = 1; Z_IN = 1; FLG_C_LD = 1; FLG_Z_LD = 1;
        cyc("c1z1", 6'b110000);

        FLG_SHAD_LD = 1; FLG_C_LD = 1; FLG_Z_LD = 1; FLG_LD_SEL = 1;
        cyc("swap", 6'b000110);

        C_IN = 0; FLG_C_SET = 1; FLG_C_LD = 1;
        cyc("c_set_prio", 6'b100110);

        I_SET = 1;
        cyc("i_set", 6'b101110);

        // Single-cycle INT pulse with interrupts enabled: request on 4th edge.
        INT = 1;
        cyc("int_e1", 6'b101110);
        INT = 0;
        cyc("int_e2", 6'b101110);
        cyc("int_e3", 6'b101110);
        cyc("int_e4_req", 6'b101111);

        INT_ACK = 1;
        cyc("int_ack", 6'b100110);

        I_SET = 1;
        cyc("i_reenable", 6'b101110);

        // INT held high: exactly one request, none after acknowledge.
        INT = 1;
        cyc("held_e1", 6'b101110);
        cyc("held_e2", 6'b101110);
        cyc("held_e3", 6'b101110);
        cyc("held_e4_req", 6'b101111);
        INT_ACK = 1;
        cyc("held_ack", 6'b100110);
        I_SET = 1;
        cyc("held_i_set", 6'b101110);
        for (int k = 0; k < 4; k++) cyc("held_no_req", 6'b101110);
        INT = 0;

        // Masked interrupt stays pending until I is set again.
        I_CLR = 1;
        cyc("cli", 6'b100110);
        INT = 1;
        cyc("masked_e1", 6'b100110);
        INT = 0;
        for (int k = 0; k < 4; k++) cyc("masked_no_req", 6'b100110);
        I_SET = 1;
        cyc("sei_pending", 6'b101110);
        cyc("sei_req", 6'b101111);

        // Asynchronous reset while a request is pending.
        @(posedge CLK);
        #1;
        RST = 1;
        #1;
        expect_now("rst_async", 6'b000000);
        @(negedge CLK);
        #1;
        RST = 0;

        I_SET = 1;
        cyc("post_rst_i", 6'b001000);
        cyc("post_rst_no_stale", 6'b001000);

        INT = 1;
        cyc("post_rst_e1", 6'b001000);
        INT = 0;
        cyc("post_rst_e2", 6'b001000);
        cyc("post_rst_e3", 6'b001000);
        cyc("post_rst_e4_req", 6'b001001);

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 5 && q_exp.size() > 0; k++) @(negedge CLK);
        #1;
        if (q_exp.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q_exp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rat_flags.md
# rat_flags

Flag-state block of the RAT MCU, directly downstream of the C/Z flag-load muxes. It holds the architectural C, Z and I flags, the C/Z shadow copies saved on interrupt entry and restored on RETIE, and the interrupt request logic gated by I. The control unit drives all load/set/clear strobes. Flag outputs feed the branch-condition logic and the ALU carry-in.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- C_IN  in  1  ALU carry result.
- Z_IN  in  1  ALU zero result.
- FLG_C_LD  in  1  load C from selected source.
- FLG_C_SET  in  1  force C=1.
- FLG_C_CLR  in  1  force C=0.
- FLG_Z_LD  in  1  load Z from selected source.
- FLG_LD_SEL  in  1  source select: 0 = ALU (C_IN/Z_IN), 1 = shadow (SHAD_C/SHAD_Z).
- FLG_SHAD_LD  in  1  copy live C/Z into shadow.
- I_SET  in  1  enable interrupts (SEI, RETIE).
- I_CLR  in  1  disable interrupts (CLI, interrupt entry).
- INT  in  1  asynchronous external interrupt line.
- INT_ACK  in  1  control unit has entered the interrupt cycle.
- C_FLAG  out  1  live carry flag.
- Z_FLAG  out  1  live zero flag.
- I_FLAG  out  1  interrupt enable.
- SHAD_C  out  1  shadow carry.
- SHAD_Z  out  1  shadow zero.
- INT_REQ  out  1  registered interrupt request to the control unit.

## Operation
- Reset: C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_REQ all 0; synchronizer, edge-detect and pending latch all 0.
- C next-state priority: FLG_C_CLR > FLG_C_SET > FLG_C_LD > hold. Load value is C_IN when FLG_LD_SEL=0, SHAD_C when 1.
- Z next-state: FLG_Z_LD loads Z_IN (sel 0) or SHAD_Z (sel 1), otherwise hold. No set/clear on Z.
- Shadow: FLG_SHAD_LD captures the current (pre-edge) C_FLAG/Z_FLAG. Otherwise hold.
- Simultaneous FLG_SHAD_LD and restore-load (sel 1): live and shadow swap. Both sides use pre-edge values.
- I next-state priority: I_CLR > I_SET > hold. INT_ACK also clears I on the same edge.
- INT path:
  - Two-flop synchronizer, then rising-edge detect on the synchronized signal.
  - A detected edge sets the pending latch. INT_ACK clears it.
  - Edge and INT_ACK on the same cycle: set wins, so the new event is not lost.
  - Level-held INT produces exactly one pending event.
- INT_REQ register: next value = pending & I_FLAG & ~INT_ACK. A pending event persists while I=0 and is requested once I returns to 1.

## Timing
- All flag loads, set/clear and shadow capture take effect one cycle after the strobe (visible after the rising edge).
- Outputs are registered only. No combinational path from any input to any output.
- INT rising edge to INT_REQ high: 4 edges when I_FLAG=1 (sync1, sync2, edge/pending, INT_REQ).
- INT_ACK at edge N: pending=0, I_FLAG=0 and INT_REQ=0 after edge N.
- I_SET with a pending event: INT_REQ rises 1 cycle after I_FLAG rises.
- Reset mid-operation clears everything immediately, including a pending interrupt. The first INT edge after reset release is detected normally. INT held high through reset release counts as an edge.

## Test plan
- Reset, then C_IN=1, Z_IN=1, FLG_C_LD=FLG_Z_LD=1, sel=0 for 1 cycle -> C_FLAG=1, Z_FLAG=1 next cycle. SHAD_C/Z remain 0.
- C=1: assert FLG_C_SET, FLG_C_CLR and FLG_C_LD together with C_IN=1 -> C_FLAG=0.
- Save/restore:
  - C=1, Z=0, FLG_SHAD_LD -> SHAD_C=1, SHAD_Z=0.
  - ALU loads C=0, Z=1.
  - Loads with sel=1 -> C=1, Z=0.
- Swap: C=1, Z=1, SHAD=0/0, FLG_SHAD_LD plus both loads with sel=1 in one cycle -> C=0, Z=0, SHAD_C=1, SHAD_Z=1.
- I_FLAG=1, INT pulse high 1 cycle -> INT_REQ=1 on 4th edge. INT_ACK -> INT_REQ=0, I_FLAG=0. INT held high afterwards -> no new request.
- I_FLAG=0, INT pulse -> INT_REQ stays 0. I_SET -> I_FLAG=1, INT_REQ=1 one cycle later. RST asserted mid-pending -> all outputs 0 immediately.
